// File: rtl/adder_share_arb_if.sv
// rtl/adder_share_arb_if.sv - requester, adder and response bus bundle for adder_share_arb
// slave = arbiter side, master = requesters, adder and response consumer.
interface adder_share_arb_if #(
  parameter int N = 64
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req0_cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         req1_cin;

  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_s;
  logic         add_cout;
  logic         add_prop;
  logic         add_gen;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_s;
  logic         rsp_cout;
  logic         rsp_prop;
  logic         rsp_gen;

  logic         err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output add_a, add_b, add_cin,
    input  add_s, add_cout, add_prop, add_gen,
    output rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_prop, rsp_gen,
    input  rsp_ready,
    output err
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  add_a, add_b, add_cin,
    output add_s, add_cout, add_prop, add_gen,
    input  rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_prop, rsp_gen,
    output rsp_ready,
    input  err
  );
endinterface

// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin sharing of one combinational adder between two requesters
// Optional result checker enabled by defining ADDER_SHARE_CHECK_EN; otherwise err is tied low.
module adder_share_arb #(
  parameter int N      = 64,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_share_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic         last_grant_q;
  logic [N-1:0] add_a_q;
  logic [N-1:0] add_b_q;
  logic         add_cin_q;
  logic         rsp_valid_q;
  logic         rsp_id_q;
  logic [N-1:0] rsp_s_q;
  logic         rsp_cout_q;
  logic         rsp_prop_q;
  logic         rsp_gen_q;

  logic         grant_vld_d;
  logic         grant_id_d;
  logic         take_d;
  logic         capture_d;
  logic [N-1:0] op_a_d;
  logic [N-1:0] op_b_d;
  logic         op_cin_d;

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant_vld_d = bus.req0_valid | bus.req1_valid;
    grant_id_d  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id_d = ~last_grant_q;
    end else begin
      grant_id_d = bus.req1_valid;
    end
    take_d    = rst_n && (state_q == IDLE) && grant_vld_d;
    capture_d = (state_q == WAIT) && (cnt_q == 4'd1);
    op_a_d    = grant_id_d ? bus.req1_a   : bus.req0_a;
    op_b_d    = grant_id_d ? bus.req1_b   : bus.req0_b;
    op_cin_d  = grant_id_d ? bus.req1_cin : bus.req0_cin;
  end

  assign bus.req0_ready = take_d & ~grant_id_d;
  assign bus.req1_ready = take_d &  grant_id_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_s_q      <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_prop_q   <= 1'b0;
      rsp_gen_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Operand registers only move on a handshake to keep adder inputs quiet.
          if (take_d) begin
            add_a_q      <= op_a_d;
            add_b_q      <= op_b_d;
            add_cin_q    <= op_cin_d;
            rsp_id_q     <= grant_id_d;
            last_grant_q <= grant_id_d;
            cnt_q        <= SETTLE_C;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (capture_d) begin
            rsp_s_q     <= bus.add_s;
            rsp_cout_q  <= bus.add_cout;
            rsp_prop_q  <= bus.add_prop;
            rsp_gen_q   <= bus.add_gen;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_s     = rsp_s_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_prop  = rsp_prop_q;
  assign bus.rsp_gen   = rsp_gen_q;

`ifdef ADDER_SHARE_CHECK_EN
  logic         err_q;
  logic [N:0]   chk_sum_d;
  logic         chk_bad_d;

  always_comb begin
    chk_sum_d = {1'b0, add_a_q} + {1'b0, add_b_q} + {{N{1'b0}}, add_cin_q};
    chk_bad_d = chk_sum_d != {bus.add_cout, bus.add_s};
  end

  // Sticky: once the adder is caught disagreeing, only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (capture_d && chk_bad_d) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - randomized self-checking bench for adder_share_arb
module tb_adder_share_arb;
  localparam int N      = 64;
  localparam int SETTLE = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   m_last = 1'b1;
  logic         inj_en = 1'b0;
  logic [N-1:0] inj_s  = '0;
  logic [N:0]   full_sum;
  logic [N:0]   half_sum;

  adder_share_arb_if #(.N(N)) bus ();

  adder_share_arb #(.N(N), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder under test stand-in, with a hook to corrupt the sum.
  assign full_sum     = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{N{1'b0}}, bus.add_cin};
  assign half_sum     = {1'b0, bus.add_a} + {1'b0, bus.add_b};
  assign bus.add_s    = inj_en ? inj_s : full_sum[N-1:0];
  assign bus.add_cout = full_sum[N];
  assign bus.add_prop = &(bus.add_a ^ bus.add_b);
  assign bus.add_gen  = half_sum[N];

  function automatic bit exp_grant(input bit v0, input bit v1);
    if (v0 && v1) return ~m_last;
    return v1;
  endfunction

  function automatic logic [N-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    inj_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit v0, input bit v1,
                       input logic [N-1:0] a0, input logic [N-1:0] b0, input logic c0,
                       input logic [N-1:0] a1, input logic [N-1:0] b1, input logic c1,
                       input bit drop, output bit got, output bit r0, output bit r1,
                       output int hs_cyc);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_cin = c0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_cin = c1;
    got = 1'b0; r0 = 1'b0; r1 = 1'b0; hs_cyc = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        r0  = bus.req0_ready;
        r1  = bus.req1_ready;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      hs_cyc = cyc;
    end
    if (drop) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int lat, output bit got);
    lat = 0;
    got = bus.rsp_valid;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      got = bus.rsp_valid;
    end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1; bus.req0_a = '1; bus.req0_b = '1; bus.req0_cin = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_a = '1; bus.req1_b = '1; bus.req1_cin = 1'b1;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_prop, bus.rsp_gen, bus.add_cin, bus.err} !== 7'd0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000000",
                        {bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_prop, bus.rsp_gen, bus.add_cin, bus.err});
    end
    n_cmp++;
    if ({bus.add_a, bus.add_b, bus.rsp_s} !== {3*N{1'b0}}) begin
      n_bad++; $display("FAIL reset_data: got a=%h b=%h s=%h want 0", bus.add_a, bus.add_b, bus.rsp_s);
    end
    do_reset();
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 3'b000) begin
      n_bad++; $display("FAIL idle_quiet: got %b want 000", {bus.req0_ready, bus.req1_ready, bus.rsp_valid});
    end
  endtask

  task automatic test_single();
    bit got, r0, r1, gr;
    int hs, lat;
    do_reset();
    issue(1'b1, 1'b0, 64'h1, '1, 1'b0, '0, '0, 1'b0, 1'b1, got, r0, r1, hs);
    n_cmp++;
    if ({got, r0, r1} !== 3'b110) begin
      n_bad++; $display("FAIL single_grant: got hs/r0/r1=%b want 110", {got, r0, r1});
    end
    m_last = 1'b0;
    wait_rsp(lat, gr);
    n_cmp++;
    if (!gr || lat !== SETTLE) begin
      n_bad++; $display("FAIL single_latency: got %0d want %0d", lat, SETTLE);
    end
    n_cmp++;
    if ({bus.rsp_s, bus.rsp_cout, bus.rsp_id, bus.rsp_prop, bus.rsp_gen} !== {{N{1'b0}}, 4'b1001}) begin
      n_bad++; $display("FAIL single_result: got s=%h c=%b id=%b p=%b g=%b want s=0 c=1 id=0 p=0 g=1",
                        bus.rsp_s, bus.rsp_cout, bus.rsp_id, bus.rsp_prop, bus.rsp_gen);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    bit got, r0, r1, gr, eg;
    int hs, prev_hs, lat;
    logic [N-1:0] a0, b0, a1, b1, ea, eb;
    logic c0, c1, ec;
    logic [N:0] ef;
    do_reset();
    bus.rsp_ready = 1'b1;
    prev_hs = 0;
    for (int i = 0; i < 8; i++) begin
      a0 = rnd_op(); b0 = rnd_op(); c0 = 1'($urandom());
      a1 = rnd_op(); b1 = rnd_op(); c1 = 1'($urandom());
      eg = exp_grant(1'b1, 1'b1);
      issue(1'b1, 1'b1, a0, b0, c0, a1, b1, c1, 1'b0, got, r0, r1, hs);
      n_cmp++;
      if (!got || r0 !== ~eg || r1 !== eg) begin
        n_bad++; $display("FAIL b2b_grant[%0d]: got r0=%b r1=%b want grant %0d", i, r0, r1, eg);
      end
      m_last = eg;
      if (i > 0) begin
        n_cmp++;
        if (hs - prev_hs !== SETTLE + 2) begin
          n_bad++; $display("FAIL b2b_period[%0d]: got %0d want %0d", i, hs - prev_hs, SETTLE + 2);
        end
      end
      prev_hs = hs;
      ea = eg ? a1 : a0; eb = eg ? b1 : b0; ec = eg ? c1 : c0;
      ef = {1'b0, ea} + {1'b0, eb} + {{N{1'b0}}, ec};
      wait_rsp(lat, gr);
      n_cmp++;
      if (!gr || lat !== SETTLE || bus.rsp_id !== eg || {bus.rsp_cout, bus.rsp_s} !== ef) begin
        n_bad++; $display("FAIL b2b_rsp[%0d]: got lat=%0d id=%b sum=%h want lat=%0d id=%b sum=%h",
                          i, lat, bus.rsp_id, {bus.rsp_cout, bus.rsp_s}, SETTLE, eg, ef);
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit got, r0, r1, gr;
    int hs, lat;
    do_reset();
    issue(1'b1, 1'b0, 64'd5, 64'd7, 1'b1, '0, '0, 1'b0, 1'b1, got, r0, r1, hs);
    m_last = 1'b0;
    wait_rsp(lat, gr);
    bus.req0_valid = 1'b1; bus.req0_a = 64'd100; bus.req0_b = 64'd1; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 64'd200; bus.req1_b = 64'd2; bus.req1_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_s !== 64'd13 || bus.rsp_id !== 1'b0 ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got v=%b s=%0d id=%b rdy=%b%b want v=1 s=13 id=0 rdy=00",
                          i, bus.rsp_valid, bus.rsp_s, bus.rsp_id, bus.req0_ready, bus.req1_ready);
      end
      @(posedge clk);
      #1;
    end
    finish_rsp();
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_release: got rsp_valid=%b want 0", bus.rsp_valid);
    end
    issue(1'b1, 1'b1, 64'd100, 64'd1, 1'b0, 64'd200, 64'd2, 1'b0, 1'b1, got, r0, r1, hs);
    n_cmp++;
    if ({got, r0, r1} !== 3'b101) begin
      n_bad++; $display("FAIL stall_next_grant: got hs/r0/r1=%b want 101", {got, r0, r1});
    end
    m_last = 1'b1;
    wait_rsp(lat, gr);
    n_cmp++;
    if (!gr || bus.rsp_s !== 64'd202 || bus.rsp_id !== 1'b1) begin
      n_bad++; $display("FAIL stall_next_rsp: got s=%0d id=%b want s=202 id=1", bus.rsp_s, bus.rsp_id);
    end
    finish_rsp();
  endtask

  task automatic test_operand_hold();
    bit got, r0, r1, gr;
    int hs, lat;
    logic [N-1:0] xa, xb, na;
    do_reset();
    xa = {$urandom(), $urandom()};
    xb = {$urandom(), $urandom()};
    issue(1'b0, 1'b1, '0, '0, 1'b0, xa, xb, 1'b1, 1'b0, got, r0, r1, hs);
    m_last = 1'b1;
    for (int i = 0; i < SETTLE + 2; i++) begin
      bus.req1_a = rnd_op(); bus.req1_b = rnd_op(); bus.req1_cin = 1'b0;
      bus.req0_a = rnd_op(); bus.req0_valid = 1'($urandom());
      #1;
      n_cmp++;
      if (bus.add_a !== xa || bus.add_b !== xb || bus.add_cin !== 1'b1) begin
        n_bad++; $display("FAIL hold_ops[%0d]: got a=%h b=%h c=%b want a=%h b=%h c=1",
                          i, bus.add_a, bus.add_b, bus.add_cin, xa, xb);
      end
      @(posedge clk);
      #1;
    end
    wait_rsp(lat, gr);
    bus.req0_valid = 1'b0;
    finish_rsp();
    na = {$urandom(), $urandom()};
    issue(1'b0, 1'b1, '0, '0, 1'b0, na, 64'd3, 1'b0, 1'b1, got, r0, r1, hs);
    n_cmp++;
    if (!got || bus.add_a !== na || bus.add_b !== 64'd3) begin
      n_bad++; $display("FAIL hold_reload: got a=%h b=%h want a=%h b=3", bus.add_a, bus.add_b, na);
    end
    wait_rsp(lat, gr);
    finish_rsp();
  endtask

  task automatic test_random();
    bit got, r0, r1, gr, eg, v0, v1;
    int hs, lat, pat, stall;
    logic [N-1:0] a0, b0, a1, b1, ea, eb;
    logic c0, c1, ec;
    logic [N:0] ef, eh;
    logic ep;
    for (int i = 0; i < 30; i++) begin
      pat = $urandom_range(1, 3);
      v0 = pat[0]; v1 = pat[1];
      a0 = rnd_op(); b0 = rnd_op(); c0 = 1'($urandom());
      a1 = rnd_op(); b1 = rnd_op(); c1 = 1'($urandom());
      eg = exp_grant(v0, v1);
      issue(v0, v1, a0, b0, c0, a1, b1, c1, 1'b1, got, r0, r1, hs);
      n_cmp++;
      if (!got || r0 !== ~eg || r1 !== eg) begin
        n_bad++; $display("FAIL rand_grant[%0d]: got r0=%b r1=%b want grant %0d (v=%b%b)", i, r0, r1, eg, v1, v0);
      end
      m_last = eg;
      ea = eg ? a1 : a0; eb = eg ? b1 : b0; ec = eg ? c1 : c0;
      ef = {1'b0, ea} + {1'b0, eb} + {{N{1'b0}}, ec};
      eh = {1'b0, ea} + {1'b0, eb};
      ep = &(ea ^ eb);
      wait_rsp(lat, gr);
      n_cmp++;
      if (!gr || lat !== SETTLE) begin
        n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, SETTLE);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || {bus.rsp_cout, bus.rsp_s} !== ef || bus.rsp_id !== eg ||
            bus.rsp_prop !== ep || bus.rsp_gen !== eh[N]) begin
          n_bad++; $display("FAIL rand_rsp[%0d.%0d]: got v=%b sum=%h id=%b p=%b g=%b want v=1 sum=%h id=%b p=%b g=%b",
                            i, s, bus.rsp_valid, {bus.rsp_cout, bus.rsp_s}, bus.rsp_id, bus.rsp_prop,
                            bus.rsp_gen, ef, eg, ep, eh[N]);
        end
        if (s < stall) begin
          @(posedge clk);
          #1;
        end
      end
      finish_rsp();
    end
  endtask

  task automatic test_reset_mid_wait();
    bit got, r0, r1, gr;
    int hs, lat;
    do_reset();
    issue(1'b1, 1'b0, '1, '1, 1'b1, '0, '0, 1'b0, 1'b0, got, r0, r1, hs);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rsp_valid, bus.req0_ready, bus.add_cin} !== 3'b000 || bus.add_a !== '0 || bus.add_b !== '0) begin
      n_bad++; $display("FAIL async_reset: got v=%b rdy=%b c=%b a=%h b=%h want all 0",
                        bus.rsp_valid, bus.req0_ready, bus.add_cin, bus.add_a, bus.add_b);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_rsp: got rsp_valid=%b want 0", bus.rsp_valid);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 1'b1;
    issue(1'b1, 1'b1, 64'd9, 64'd1, 1'b0, 64'd4, 64'd4, 1'b0, 1'b1, got, r0, r1, hs);
    n_cmp++;
    if ({got, r0, r1} !== 3'b110) begin
      n_bad++; $display("FAIL reset_first_grant: got hs/r0/r1=%b want 110", {got, r0, r1});
    end
    m_last = 1'b0;
    wait_rsp(lat, gr);
    n_cmp++;
    if (!gr || lat !== SETTLE || bus.rsp_s !== 64'd10 || bus.rsp_id !== 1'b0) begin
      n_bad++; $display("FAIL reset_first_rsp: got lat=%0d s=%0d id=%b want lat=%0d s=10 id=0",
                        lat, bus.rsp_s, bus.rsp_id, SETTLE);
    end
    finish_rsp();
  endtask

  task automatic test_checker();
    bit got, r0, r1, gr;
    int hs, lat;
    do_reset();
    inj_en = 1'b1;
    inj_s  = 64'd3;
    issue(1'b1, 1'b0, 64'd1, 64'd1, 1'b0, '0, '0, 1'b0, 1'b1, got, r0, r1, hs);
    wait_rsp(lat, gr);
    inj_en = 1'b0;
`ifdef ADDER_SHARE_CHECK_EN
    n_cmp++;
    if (!gr || bus.err !== 1'b1) begin
      n_bad++; $display("FAIL chk_flag: got err=%b want 1", bus.err);
    end
    finish_rsp();
    issue(1'b1, 1'b0, 64'd2, 64'd2, 1'b0, '0, '0, 1'b0, 1'b1, got, r0, r1, hs);
    wait_rsp(lat, gr);
    finish_rsp();
    n_cmp++;
    if (bus.err !== 1'b1) begin
      n_bad++; $display("FAIL chk_sticky: got err=%b want 1", bus.err);
    end
    do_reset();
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_bad++; $display("FAIL chk_clear: got err=%b want 0", bus.err);
    end
`else
    n_cmp++;
    if (!gr || bus.err !== 1'b0 || bus.rsp_s !== 64'd3) begin
      n_bad++; $display("FAIL chk_off: got err=%b s=%0d want err=0 s=3", bus.err, bus.rsp_s);
    end
    finish_rsp();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_operand_hold();
    test_random();
    test_reset_mid_wait();
    test_checker();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout at cycle %0d want completion", cyc);
    $fatal(1);
  end

endmodule
